// File: rtl/dispatch_spec_tracker_pkg.sv
// Shared types for the dispatch speculation tracker:
// FSM state encoding and counter-width helper.
package dispatch_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        BR_FULL   = 2'd1,
        JALR_WAIT = 2'd2,
        FLUSH     = 2'd3
    } disp_state_e;

    // Width of a down-counter that must hold values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dispatch_spec_tracker_if.sv
// Dispatch-head control bundle between the dispatch stage
// and the speculation tracker.
interface dispatch_spec_tracker_if #(
    parameter int MAX_BR = 4
);
    logic                          branch;
    logic                          jalr;
    logic                          branch_solved;
    logic                          jalr_solved;
    logic                          flush;
    logic                          ifq_empty;
    logic                          nstall;
    logic [$clog2(MAX_BR+1)-1:0]   br_cnt;
    logic [1:0]                    state_o;
    logic                          err;
`ifdef DISPATCH_STALL_STATS_EN
    logic [15:0]                   stall_cycles;

    modport master (
        output branch, jalr, branch_solved, jalr_solved,
        output flush, ifq_empty,
        input  nstall, br_cnt, state_o, err, stall_cycles
    );

    modport slave (
        input  branch, jalr, branch_solved, jalr_solved,
        input  flush, ifq_empty,
        output nstall, br_cnt, state_o, err, stall_cycles
    );
`else
    modport master (
        output branch, jalr, branch_solved, jalr_solved,
        output flush, ifq_empty,
        input  nstall, br_cnt, state_o, err
    );

    modport slave (
        input  branch, jalr, branch_solved, jalr_solved,
        input  flush, ifq_empty,
        output nstall, br_cnt, state_o, err
    );
`endif
endinterface

// File: rtl/dispatch_spec_tracker_flush_timer.sv
// Post-flush hold countdown: load on flush, count down while
// flushing, done when the count reads zero.
module flush_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/dispatch_spec_tracker.sv
// Tracks speculatively dispatched branches/JALR and gates dispatch.
// DISPATCH_STALL_STATS_EN adds a saturating stall_cycles counter.
module dispatch_spec_tracker
    import dispatch_pkg::*;
#(
    parameter int MAX_BR       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dispatch_spec_tracker_if.slave  bus
);

    localparam int CW = $clog2(MAX_BR + 1);
    localparam int FW = cnt_w(FLUSH_CYCLES);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BR);
    localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYCLES - 1);

    disp_state_e   state_q;
    disp_state_e   state_d;
    logic [CW-1:0] br_cnt_q;
    logic [CW-1:0] br_cnt_d;
    logic          err_q;
    logic          err_d;
    logic          nstall;
    logic          br_disp;
    logic          jalr_disp;
    logic          br_inc;
    logic          br_dec;
    logic          fl_load;
    logic          fl_dec;
    logic          fl_done;
`ifdef DISPATCH_STALL_STATS_EN
    logic [15:0]   stall_q;
    logic [15:0]   stall_d;
`endif

    flush_timer #(.W(FW)) u_flush_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (fl_load),
        .load_val (FLOAD),
        .dec      (fl_dec),
        .done     (fl_done)
    );

    always_comb begin
        state_d   = state_q;
        br_cnt_d  = br_cnt_q;
        err_d     = err_q;
        nstall    = (state_q == RUN) && !bus.ifq_empty;
        br_disp   = bus.branch && nstall;
        jalr_disp = bus.jalr && nstall && !bus.branch;
        fl_load   = bus.flush;
        fl_dec    = (state_q == FLUSH);
        br_inc    = br_disp && (br_cnt_q != MAX_C);
        br_dec    = bus.branch_solved && (br_cnt_q != '0)
                    && (state_q != FLUSH);
`ifdef DISPATCH_STALL_STATS_EN
        stall_d   = stall_q;
        if (!nstall && !bus.ifq_empty && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
`endif

        if (bus.branch_solved && (br_cnt_q == '0) && (state_q != FLUSH))
            err_d = 1'b1;
        if (bus.jalr_solved && (state_q != JALR_WAIT)
            && (state_q != FLUSH))
            err_d = 1'b1;
        if (bus.branch && bus.jalr && nstall)
            err_d = 1'b1;

        if (br_inc && !br_dec)
            br_cnt_d = br_cnt_q + CW'(1);
        else if (!br_inc && br_dec)
            br_cnt_d = br_cnt_q - CW'(1);

        // Flush overrides every other input, including solves.
        if (bus.flush) begin
            state_d  = FLUSH;
            br_cnt_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (jalr_disp)
                        state_d = JALR_WAIT;
                    else if (br_cnt_d == MAX_C)
                        state_d = BR_FULL;
                end
                BR_FULL: begin
                    if (br_cnt_d < MAX_C)
                        state_d = RUN;
                end
                JALR_WAIT: begin
                    if (bus.jalr_solved)
                        state_d = RUN;
                end
                FLUSH: begin
                    if (fl_done)
                        state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            br_cnt_q <= '0;
            err_q    <= 1'b0;
`ifdef DISPATCH_STALL_STATS_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            br_cnt_q <= br_cnt_d;
            err_q    <= err_d;
`ifdef DISPATCH_STALL_STATS_EN
            stall_q  <= stall_d;
`endif
        end
    end

    assign bus.nstall  = nstall;
    assign bus.br_cnt  = br_cnt_q;
    assign bus.state_o = state_q;
    assign bus.err     = err_q;
`ifdef DISPATCH_STALL_STATS_EN
    assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_dispatch_spec_tracker.sv
// Directed scoreboard bench for dispatch_spec_tracker
// (MAX_BR=4, FLUSH_CYCLES=2).
module tb_dispatch_spec_tracker;

    localparam int RUN = 0, BRF = 1, JW = 2, FL = 3;

    typedef struct {
        int id;
        int cnt;
        int st;
        int ns;
        int er;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   step_id = 0;
    exp_t q[$];
    event async_ev;

    always #5 clk = ~clk;

    dispatch_spec_tracker_if #(.MAX_BR(4)) bus ();

    dispatch_spec_tracker #(
        .MAX_BR       (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic drive(input logic br, input logic jl,
                         input logic bs, input logic js,
                         input logic fl, input logic ie);
        bus.branch        = br;
        bus.jalr          = jl;
        bus.branch_solved = bs;
        bus.jalr_solved   = js;
        bus.flush         = fl;
        bus.ifq_empty     = ie;
    endtask

    task automatic push(input int c, input int s,
                        input int n, input int e);
        exp_t x;
        step_id++;
        x.id  = step_id;
        x.cnt = c;
        x.st  = s;
        x.ns  = n;
        x.er  = e;
        q.push_back(x);
    endtask

    // Drive one cycle of inputs; expectation is for after the edge.
    task automatic step(input logic br, input logic jl,
                        input logic bs, input logic js,
                        input logic fl, input logic ie,
                        input int c, input int s,
                        input int n, input int e);
        @(negedge clk);
        drive(br, jl, bs, js, fl, ie);
        push(c, s, n, e);
    endtask

    // Assert reset mid-cycle, check outputs before any clock edge.
    task automatic async_rst;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        push(0, RUN, 1, 0);
        ->async_ev;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                n_total++;
                if (int'(bus.br_cnt) == x.cnt && int'(bus.state_o) == x.st
                    && int'(bus.nstall) == x.ns && int'(bus.err) == x.er)
                    n_pass++;
                else
                    $display("FAIL step%0d: got cnt=%0d st=%0d ns=%0d err=%0d want cnt=%0d st=%0d ns=%0d err=%0d",
                             x.id, bus.br_cnt, bus.state_o, bus.nstall,
                             bus.err, x.cnt, x.st, x.ns, x.er);
            end
        end
    end

    initial begin : stim
        drive(0, 0, 0, 0, 0, 0);
        async_rst();
        // four back-to-back branches fill the window
        step(1, 0, 0, 0, 0, 0, 1, RUN, 1, 0);
        step(1, 0, 0, 0, 0, 0, 2, RUN, 1, 0);
        step(1, 0, 0, 0, 0, 0, 3, RUN, 1, 0);
        step(1, 0, 0, 0, 0, 0, 4, BRF, 0, 0);
        step(1, 0, 0, 0, 0, 0, 4, BRF, 0, 0);
        step(0, 0, 1, 0, 0, 0, 3, RUN, 1, 0);
        // dispatch and solve together
        step(1, 0, 1, 0, 0, 0, 3, RUN, 1, 0);
        step(0, 0, 1, 0, 0, 0, 2, RUN, 1, 0);
        // jalr at br_cnt=2
        step(0, 1, 0, 0, 0, 0, 2, JW, 0, 0);
        step(0, 0, 1, 0, 0, 0, 1, JW, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, JW, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, RUN, 1, 0);
        // flush from BR_FULL
        step(1, 0, 0, 0, 0, 0, 1, RUN, 1, 0);
        step(1, 0, 0, 0, 0, 0, 2, RUN, 1, 0);
        step(1, 0, 0, 0, 0, 0, 3, RUN, 1, 0);
        step(1, 0, 0, 0, 0, 0, 4, BRF, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, FL, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, FL, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, RUN, 1, 0);
        // flush re-asserted in first flush cycle
        step(1, 0, 0, 0, 0, 0, 1, RUN, 1, 0);
        step(1, 0, 0, 0, 0, 0, 2, RUN, 1, 0);
        step(1, 0, 0, 0, 0, 0, 3, RUN, 1, 0);
        step(1, 0, 0, 0, 0, 0, 4, BRF, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, FL, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, FL, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, FL, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, RUN, 1, 0);
        // empty fetch queue blocks dispatch
        step(1, 0, 0, 0, 0, 1, 0, RUN, 0, 0);
        // solve with nothing pending: sticky err
        step(0, 0, 1, 0, 0, 0, 0, RUN, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, RUN, 1, 1);
        step(1, 0, 0, 0, 0, 0, 1, RUN, 1, 1);
        step(0, 1, 0, 0, 0, 0, 1, JW, 0, 1);
        // async reset mid-JALR_WAIT
        async_rst();
        step(0, 0, 0, 0, 0, 0, 0, RUN, 1, 0);
        // branch and jalr together is a protocol error
        step(1, 1, 0, 0, 0, 0, 1, RUN, 1, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dispatch_spec_tracker.md
DISPATCH_SPEC_TRACKER -- requirements
Module: dispatch_spec_tracker

Interface
REQ-001 SHALL have parameter MAX_BR, default 4, max unresolved branches dispatched speculatively (>=1).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, dispatch-blocked cycles after a flush (>=1).
REQ-003 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: branch  in  1  conditional branch at dispatch head; jalr  in  1  JALR at dispatch head.
REQ-005 SHALL have ports: branch_solved  in  1  one branch resolved; jalr_solved  in  1  pending JALR target resolved.
REQ-006 SHALL have ports: flush  in  1  mispredict flush; ifq_empty  in  1  instruction fetch queue empty.
REQ-007 SHALL have ports: nstall  out  1  dispatch allowed; br_cnt  out  $clog2(MAX_BR+1)  unresolved branches; state_o  out  2  FSM state; err  out  1  sticky protocol error.

Function
REQ-008 SHALL implement states RUN, BR_FULL, JALR_WAIT, FLUSH, encoded 0..3 on state_o.
REQ-009 SHALL drive nstall = (state==RUN) & !ifq_empty, combinationally.
REQ-010 SHALL count a branch as dispatched only when branch & nstall; a jalr only when jalr & nstall & !branch.
REQ-011 SHALL set br_cnt_next = br_cnt + dispatched branch - (branch_solved & br_cnt!=0); dispatch and solve in the same cycle leave br_cnt unchanged.
REQ-012 SHALL, from RUN, go to JALR_WAIT on dispatched jalr; to BR_FULL when br_cnt_next==MAX_BR; else stay RUN.
REQ-013 SHALL, from BR_FULL, return to RUN when br_cnt_next<MAX_BR.
REQ-014 SHALL, from JALR_WAIT, go to RUN on jalr_solved; branch_solved still decrements br_cnt while waiting.
REQ-015 SHALL, on flush in any state, enter FLUSH, zero br_cnt, clear pending JALR, load flush counter with FLUSH_CYCLES-1; flush has priority over all other inputs.
REQ-016 SHALL, in FLUSH, ignore branch_solved/jalr_solved, decrement flush counter each cycle, exit to RUN the cycle after it reads 0; flush reasserted restarts the count.
REQ-017 SHALL set err (sticky until reset) on: branch_solved with br_cnt==0 outside FLUSH; jalr_solved outside JALR_WAIT and FLUSH; branch & jalr both high while nstall.
REQ-018 SHALL never let br_cnt exceed MAX_BR nor underflow below 0.

Reset
REQ-019 SHALL, on rst_n low, asynchronously force state RUN, br_cnt 0, flush counter 0, err 0; nstall then follows !ifq_empty.
REQ-020 SHALL release reset synchronously to clk; reset mid-FLUSH or mid-JALR_WAIT returns to RUN with no residue.

Configuration
REQ-021 SHALL, with DISPATCH_STALL_STATS_EN defined, add output stall_cycles (16-bit) counting cycles with nstall==0 & ifq_empty==0, saturating at 16'hFFFF, reset to 0.
REQ-022 SHALL, without DISPATCH_STALL_STATS_EN, omit stall_cycles port and its counter entirely.

Structure
REQ-023 SHALL place the state enum typedef and the FSM state encodings in shared package dispatch_pkg.
REQ-024 SHALL implement the flush-hold countdown as sub-module flush_timer (load, decrement, done).
REQ-025 SHALL keep remaining logic in one module of two always blocks (comb next-state/nstall, seq registers).

Verification
REQ-026 SHALL test: MAX_BR=4, 4 branches dispatched back-to-back, no solves -> br_cnt=4, state BR_FULL, nstall=0 in cycle 5; one branch_solved -> RUN next cycle.
REQ-027 SHALL test: jalr dispatched at br_cnt=2 -> JALR_WAIT, nstall=0; branch_solved x2 -> br_cnt=0; jalr_solved -> RUN, nstall=1.
REQ-028 SHALL test: br_cnt=3, branch dispatched and branch_solved same cycle -> br_cnt stays 3, state RUN.
REQ-029 SHALL test: flush in BR_FULL with FLUSH_CYCLES=2 -> br_cnt=0, nstall=0 for exactly 2 cycles, then RUN; flush re-asserted at cycle 1 -> 2 further cycles.
REQ-030 SHALL test: branch_solved at br_cnt=0 in RUN -> err=1, br_cnt=0, err stays 1 until rst_n low.
REQ-031 SHALL test: rst_n low mid-JALR_WAIT with ifq_empty=0 -> state RUN, br_cnt=0, nstall=1 immediately (asynchronous).
